irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Prioritised, nestable interrupt controller (CP0 subset) for the single-cycle MIPS core.
- Accepts three external interrupt lines and tracks which are pending and which are in service.
- Decides when to redirect the PC to a per-source entry vector, and keeps a 3-deep EPC stack so `eret` returns correctly through nested handlers.
- Sits beside the PC mux: the core selects `irq_target` when `take_irq` is high and `eret_target` when executing `eret`.

Parameters:
- VEC2, 32'h0000_0100, entry address for source 2 (highest priority).
- VEC1, 32'h0000_0200, entry address for source 1.
- VEC0, 32'h0000_0300, entry address for source 0 (lowest priority).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  3  external interrupt lines, level; a rising edge raises a request.
- pc_next  in  32  address of the instruction the core would execute next; pushed as EPC.
- stall  in  1  core halted or stalled; suppresses taking an interrupt.
- eret  in  1  current instruction is `eret`; pops the EPC stack.
- mask_we  in  1  write enable for the mask register.
- mask_wdata  in  3  new mask; bit i=1 blocks source i.
- ie_we  in  1  write enable for global interrupt enable.
- ie_wdata  in  1  new global enable value.
- take_irq  out  1  redirect PC to `irq_target` this cycle (combinational).
- irq_target  out  32  vector of the winning source; 0 when `take_irq`=0.
- irq_id  out  2  winning source index; 0 when `take_irq`=0.
- eret_target  out  32  top of EPC stack; 0 when the stack is empty.
- in_service  out  3  sources whose handlers are active.
- pending  out  3  latched, not-yet-taken requests.
- mask  out  3  current mask register.
- ie  out  1  current global enable.
- depth  out  2  EPC stack occupancy, 0..3.

Behaviour:

Reset (`rst`=1 at a rising edge):
- `pending`, `in_service`, `mask` and `depth` become 0.
- `ie` becomes 1.
- Edge-detect history register becomes 0.
- Stack contents become 0.
- Reset overrides every other input in the same cycle, including mid-handler: all nesting is discarded.

Request capture:
- `irq_prev` holds `irq_in` from the previous cycle.
- A rising edge on source i is `irq_in[i] & ~irq_prev[i]`; it sets `pending[i]` at the next edge.
- A held-high line produces exactly one request.
- A masked or disabled source still latches `pending`; it is taken once unmasked or enabled.

Eligibility (from registered state only):
- Source i is eligible when `pending[i]` & ~`mask[i]` & `ie` & no `in_service` bit at index ≥ i.
- Priority is fixed: 2 > 1 > 0. The winner is the highest eligible index.
- A source preempts only strictly lower-priority handlers; an equal or lower priority waits.

Taking an interrupt:
- `take_irq` = any eligible & ~`stall` & ~`eret`.
- At the next edge on a take:
  - push `pc_next` onto the stack (stack[`depth`] <= `pc_next`, `depth`+1);
  - set `in_service[winner]`;
  - clear `pending[winner]`.
- If a new rising edge of the winner arrives in the same cycle as its take, the set wins: `pending` stays 1.

Return (`eret`):
- Active when `eret`=1 and `depth`>0.
- `eret_target` = stack[`depth`-1], combinational.
- At the next edge: `depth`-1, and the highest set `in_service` bit is cleared.
- `eret` with `depth`=0: no state change and `eret_target`=0.
- `eret` has priority over a take in the same cycle; an eligible request is taken in the following cycle.

Register writes:
- `mask_we` and `ie_we` update at the edge.
- Eligibility in the write cycle uses the old values, so the new value takes effect next cycle.
- Simultaneous write and take are both performed.

Stack bounds:
- Each source can be in service at most once, so `depth` ≤ 3 and overflow is impossible.
- Stack entries are 32-bit and stored without modification.

`stall`:
- Blocks taking only.
- Does not block capture, writes or `eret`.

Test Plan:
- Reset then idle: `pending`=0, `in_service`=0, `mask`=0, `ie`=1, `depth`=0, `take_irq`=0, `eret_target`=0.
- Pulse `irq_in`=3'b001 with `pc_next`=32'h40 → next cycle `take_irq`=1, `irq_target`=32'h300, `irq_id`=0; after the edge `in_service`=3'b001, `depth`=1; `eret` → `eret_target`=32'h40, then `in_service`=0, `depth`=0.
- Nesting: source 0 in service; raise source 2 with `pc_next`=32'h308 → taken, `irq_target`=32'h100, `depth`=2; raise source 1 during handler 2 → not taken until `eret` (target 32'h308), then source 1 is taken.
- Same-cycle `irq_in`=3'b111 rising → source 2 taken first; `pending`=3'b011 remains; `irq_in` held high causes no re-trigger.
- Masking: `mask_we`=1, `mask_wdata`=3'b010, then raise source 1 → `pending[1]`=1, no take; write mask 0 → `take_irq`=1 exactly one cycle after the write edge, `irq_target`=32'h200.
- Boundary conditions:
  - `eret` at `depth`=0 → no state change;
  - `eret` coinciding with an eligible request → `take_irq`=0 that cycle, 1 the next;
  - `stall`=1 holds the take until `stall`=0;
  - `rst` asserted at `depth`=2 → all state zeroed next edge.

Source files
------------

// File: rtl/irq_controller_if.sv
// Bus between the core and the interrupt controller.
// The master modport belongs to the core side and the slave modport to the controller.
interface irq_controller_if;
    logic [2:0]  irq_in;
    logic [31:0] pc_next;
    logic        stall;
    logic        eret;
    logic        mask_we;
    logic [2:0]  mask_wdata;
    logic        ie_we;
    logic        ie_wdata;
    logic        take_irq;
    logic [31:0] irq_target;
    logic [1:0]  irq_id;
    logic [31:0] eret_target;
    logic [2:0]  in_service;
    logic [2:0]  pending;
    logic [2:0]  mask;
    logic        ie;
    logic [1:0]  depth;

    modport master (
        output irq_in, pc_next, stall, eret, mask_we, mask_wdata, ie_we, ie_wdata,
        input  take_irq, irq_target, irq_id, eret_target, in_service, pending,
               mask, ie, depth
    );

    modport slave (
        input  irq_in, pc_next, stall, eret, mask_we, mask_wdata, ie_we, ie_wdata,
        output take_irq, irq_target, irq_id, eret_target, in_service, pending,
               mask, ie, depth
    );
endinterface

// File: rtl/irq_controller.sv
// Prioritised, nestable 3-source interrupt controller with a 3-deep EPC stack.
// Source 2 has the highest priority. A source may preempt only strictly lower-priority handlers.
module irq_controller #(
    parameter logic [31:0] VEC2 = 32'h0000_0100,
    parameter logic [31:0] VEC1 = 32'h0000_0200,
    parameter logic [31:0] VEC0 = 32'h0000_0300
) (
    input  logic              clk,
    input  logic              rst,
    irq_controller_if.slave   bus
);

    logic [2:0]  r_irq_prev;
    logic [2:0]  r_pending;
    logic [2:0]  r_in_service;
    logic [2:0]  r_mask;
    logic        r_ie;
    logic [1:0]  r_depth;
    logic [31:0] r_stack [0:2];

    logic [2:0]  w_rise;
    logic [2:0]  w_elig;
    logic [2:0]  w_win_oh;
    logic [1:0]  w_win_id;
    logic [31:0] w_vec;
    logic        w_take;
    logic        w_pop;
    logic [2:0]  w_clr_oh;

    // Edge detection, eligibility from registered state, and fixed-priority winner selection
    always_comb begin
        w_rise    = bus.irq_in & ~r_irq_prev;
        w_elig[2] = r_pending[2] & ~r_mask[2] & r_ie & ~r_in_service[2];
        w_elig[1] = r_pending[1] & ~r_mask[1] & r_ie & ~(|r_in_service[2:1]);
        w_elig[0] = r_pending[0] & ~r_mask[0] & r_ie & ~(|r_in_service);
        w_win_oh  = '0;
        w_win_id  = '0;
        w_vec     = '0;
        if (w_elig[2]) begin
            w_win_oh = 3'b100;
            w_win_id = 2'd2;
            w_vec    = VEC2;
        end else if (w_elig[1]) begin
            w_win_oh = 3'b010;
            w_win_id = 2'd1;
            w_vec    = VEC1;
        end else if (w_elig[0]) begin
            w_win_oh = 3'b001;
            w_win_id = 2'd0;
            w_vec    = VEC0;
        end
        // eret blocks a take even when the stack is empty
        w_take = (|w_elig) & ~bus.stall & ~bus.eret;
        w_pop  = bus.eret & (r_depth != 2'd0);
    end

    // The handler being returned from is always the highest-priority one in service
    always_comb begin
        w_clr_oh = '0;
        if (r_in_service[2])      w_clr_oh = 3'b100;
        else if (r_in_service[1]) w_clr_oh = 3'b010;
        else if (r_in_service[0]) w_clr_oh = 3'b001;
    end

    // Drive the PC-mux outputs and expose the registered state
    always_comb begin
        bus.take_irq   = w_take;
        bus.irq_target = w_take ? w_vec : '0;
        bus.irq_id     = w_take ? w_win_id : '0;
        case (r_depth)
            2'd1:    bus.eret_target = r_stack[0];
            2'd2:    bus.eret_target = r_stack[1];
            2'd3:    bus.eret_target = r_stack[2];
            default: bus.eret_target = '0;
        endcase
        bus.in_service = r_in_service;
        bus.pending    = r_pending;
        bus.mask       = r_mask;
        bus.ie         = r_ie;
        bus.depth      = r_depth;
    end

    // Control state: request capture, take/return bookkeeping and register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev   <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= '0;
            r_ie         <= 1'b1;
            r_depth      <= '0;
        end else begin
            r_irq_prev <= bus.irq_in;
            // A new edge on the winner in its take cycle re-arms the request
            r_pending  <= (r_pending & ~(w_take ? w_win_oh : 3'b000)) | w_rise;
            if (w_take) begin
                r_in_service <= r_in_service | w_win_oh;
                r_depth      <= r_depth + 2'd1;
            end else if (w_pop) begin
                r_in_service <= r_in_service & ~w_clr_oh;
                r_depth      <= r_depth - 2'd1;
            end
            if (bus.mask_we) r_mask <= bus.mask_wdata;
            if (bus.ie_we)   r_ie   <= bus.ie_wdata;
        end
    end

    // EPC stack: push the return address into the slot at the current depth
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 3; k++) begin
            if (rst) begin
                r_stack[k] <= '0;
            end else if (w_take && (r_depth == 2'(k))) begin
                r_stack[k] <= bus.pc_next;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a queue-based reference model is compared every cycle,
// and directed scenarios are checked against hand-computed values.
module tb_irq_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    irq_controller_if bus_if ();

    irq_controller #(
        .VEC2(32'h0000_0100),
        .VEC1(32'h0000_0200),
        .VEC0(32'h0000_0300)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-service handlers are a stack of source ids, paired with a stack of EPCs
    bit [2:0]    m_pend, m_mask, m_prev, m_rise, m_isv;
    bit          m_ie;
    bit          m_valid = 1'b0;
    int          m_ids[$];
    logic [31:0] m_epc[$];
    int          e_win;
    bit          e_take;

    function automatic int m_winner();
        for (int i = 2; i >= 0; i--) begin
            if (m_pend[i] && !m_mask[i] && m_ie &&
                (m_ids.size() == 0 || m_ids[m_ids.size()-1] < i))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_vec(input int w);
        if (w == 2) return 32'h100;
        if (w == 1) return 32'h200;
        return 32'h300;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            e_win  = m_winner();
            e_take = (e_win >= 0) && !bus_if.stall && !bus_if.eret;
            m_isv  = '0;
            foreach (m_ids[k]) m_isv[m_ids[k]] = 1'b1;
            chk("m_take_irq",    {31'd0, bus_if.take_irq}, {31'd0, e_take});
            chk("m_irq_target",  bus_if.irq_target, e_take ? m_vec(e_win) : 32'h0);
            chk("m_irq_id",      {30'd0, bus_if.irq_id}, e_take ? 32'(e_win) : 32'h0);
            chk("m_eret_target", bus_if.eret_target,
                (m_epc.size() > 0) ? m_epc[m_epc.size()-1] : 32'h0);
            chk("m_in_service",  {29'd0, bus_if.in_service}, {29'd0, m_isv});
            chk("m_pending",     {29'd0, bus_if.pending}, {29'd0, m_pend});
            chk("m_mask",        {29'd0, bus_if.mask}, {29'd0, m_mask});
            chk("m_ie",          {31'd0, bus_if.ie}, {31'd0, m_ie});
            chk("m_depth",       {30'd0, bus_if.depth}, 32'(m_ids.size()));
        end
        // Advance the model with the inputs that the next rising edge will sample
        if (rst) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_ie = 1'b1;
            m_ids.delete(); m_epc.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_rise = bus_if.irq_in & ~m_prev;
            if (e_take) begin
                m_epc.push_back(bus_if.pc_next);
                m_ids.push_back(e_win);
                m_pend[e_win] = 1'b0;
            end else if (bus_if.eret && m_ids.size() > 0) begin
                void'(m_ids.pop_back());
                void'(m_epc.pop_back());
            end
            m_pend = m_pend | m_rise;
            m_prev = bus_if.irq_in;
            if (bus_if.mask_we) m_mask = bus_if.mask_wdata;
            if (bus_if.ie_we)   m_ie   = bus_if.ie_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.irq_in = '0; bus_if.pc_next = '0; bus_if.stall = 1'b0; bus_if.eret = 1'b0;
        bus_if.mask_we = 1'b0; bus_if.mask_wdata = '0; bus_if.ie_we = 1'b0; bus_if.ie_wdata = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_pending", {29'd0, bus_if.pending}, 32'h0);
        chk("rst_in_service", {29'd0, bus_if.in_service}, 32'h0);
        chk("rst_mask", {29'd0, bus_if.mask}, 32'h0);
        chk("rst_ie", {31'd0, bus_if.ie}, 32'h1);
        chk("rst_depth", {30'd0, bus_if.depth}, 32'h0);
        chk("rst_take", {31'd0, bus_if.take_irq}, 32'h0);
        chk("rst_eret_target", bus_if.eret_target, 32'h0);

        // Single source 0 round trip
        bus_if.irq_in = 3'b001; bus_if.pc_next = 32'h40;
        tick(); bus_if.irq_in = 3'b000; #1;
        chk("a_take", {31'd0, bus_if.take_irq}, 32'h1);
        chk("a_target", bus_if.irq_target, 32'h300);
        chk("a_id", {30'd0, bus_if.irq_id}, 32'h0);
        tick(); #1;
        chk("a_in_service", {29'd0, bus_if.in_service}, 32'h1);
        chk("a_depth", {30'd0, bus_if.depth}, 32'h1);
        bus_if.eret = 1'b1; #1;
        chk("a_eret_target", bus_if.eret_target, 32'h40);
        tick(); bus_if.eret = 1'b0; #1;
        chk("a_ret_in_service", {29'd0, bus_if.in_service}, 32'h0);
        chk("a_ret_depth", {30'd0, bus_if.depth}, 32'h0);

        // Nesting: 0 then 2 preempts, 1 waits until 2 returns
        do_reset();
        bus_if.irq_in = 3'b001; bus_if.pc_next = 32'h20;
        tick(); bus_if.irq_in = 3'b000;
        tick();
        bus_if.irq_in = 3'b100; bus_if.pc_next = 32'h308;
        tick(); bus_if.irq_in = 3'b000; #1;
        chk("b_take2", {31'd0, bus_if.take_irq}, 32'h1);
        chk("b_target2", bus_if.irq_target, 32'h100);
        chk("b_id2", {30'd0, bus_if.irq_id}, 32'h2);
        tick(); #1;
        chk("b_depth2", {30'd0, bus_if.depth}, 32'h2);
        chk("b_isv", {29'd0, bus_if.in_service}, 32'h5);
        bus_if.irq_in = 3'b010;
        tick(); bus_if.irq_in = 3'b000; #1;
        chk("b_pend1", {29'd0, bus_if.pending}, 32'h2);
        chk("b_no_take1", {31'd0, bus_if.take_irq}, 32'h0);
        tick();
        bus_if.eret = 1'b1; #1;
        chk("b_eret_target", bus_if.eret_target, 32'h308);
        chk("b_eret_no_take", {31'd0, bus_if.take_irq}, 32'h0);
        tick(); bus_if.eret = 1'b0; bus_if.pc_next = 32'h50; #1;
        chk("b_take1", {31'd0, bus_if.take_irq}, 32'h1);
        chk("b_target1", bus_if.irq_target, 32'h200);
        tick(); #1;
        chk("b_isv1", {29'd0, bus_if.in_service}, 32'h3);
        chk("b_epc1", bus_if.eret_target, 32'h50);
        bus_if.eret = 1'b1;
        tick(); tick(); bus_if.eret = 1'b0; #1;
        chk("b_unwound", {30'd0, bus_if.depth}, 32'h0);

        // All three rise together; held-high lines do not re-trigger
        do_reset();
        bus_if.irq_in = 3'b111; bus_if.pc_next = 32'h60;
        tick(); #1;
        chk("c_id", {30'd0, bus_if.irq_id}, 32'h2);
        tick(); #1;
        chk("c_pending", {29'd0, bus_if.pending}, 32'h3);
        chk("c_isv", {29'd0, bus_if.in_service}, 32'h4);
        tick(); tick(); #1;
        chk("c_held_pending", {29'd0, bus_if.pending}, 32'h3);
        chk("c_held_take", {31'd0, bus_if.take_irq}, 32'h0);
        bus_if.eret = 1'b1;
        tick(); bus_if.eret = 1'b0; #1;
        chk("c_next_id", {30'd0, bus_if.irq_id}, 32'h1);
        tick();

        // Masking delays the take until one cycle after the unmask edge
        do_reset();
        bus_if.mask_we = 1'b1; bus_if.mask_wdata = 3'b010;
        tick(); bus_if.mask_we = 1'b0; #1;
        chk("d_mask", {29'd0, bus_if.mask}, 32'h2);
        bus_if.irq_in = 3'b010;
        tick(); bus_if.irq_in = 3'b000; #1;
        chk("d_pending", {29'd0, bus_if.pending}, 32'h2);
        chk("d_no_take", {31'd0, bus_if.take_irq}, 32'h0);
        tick();
        bus_if.mask_we = 1'b1; bus_if.mask_wdata = 3'b000; #1;
        chk("d_write_cycle", {31'd0, bus_if.take_irq}, 32'h0);
        tick(); bus_if.mask_we = 1'b0; #1;
        chk("d_take", {31'd0, bus_if.take_irq}, 32'h1);
        chk("d_target", bus_if.irq_target, 32'h200);
        tick();

        // eret with an empty stack changes nothing
        do_reset();
        bus_if.eret = 1'b1; #1;
        chk("e_eret_target", bus_if.eret_target, 32'h0);
        tick(); bus_if.eret = 1'b0; #1;
        chk("e_depth", {30'd0, bus_if.depth}, 32'h0);
        chk("e_isv", {29'd0, bus_if.in_service}, 32'h0);

        // eret beats a same-cycle take
        do_reset();
        bus_if.irq_in = 3'b001; bus_if.pc_next = 32'h70;
        tick(); bus_if.irq_in = 3'b000;
        tick();
        bus_if.irq_in = 3'b100;
        tick(); bus_if.irq_in = 3'b000; bus_if.eret = 1'b1; #1;
        chk("f_blocked", {31'd0, bus_if.take_irq}, 32'h0);
        chk("f_eret_target", bus_if.eret_target, 32'h70);
        tick(); bus_if.eret = 1'b0; #1;
        chk("f_take", {31'd0, bus_if.take_irq}, 32'h1);
        chk("f_id", {30'd0, bus_if.irq_id}, 32'h2);
        tick();

        // stall holds the take
        do_reset();
        bus_if.stall = 1'b1; bus_if.irq_in = 3'b010;
        tick(); bus_if.irq_in = 3'b000; #1;
        chk("g_stalled", {31'd0, bus_if.take_irq}, 32'h0);
        tick(); tick(); #1;
        chk("g_pending", {29'd0, bus_if.pending}, 32'h2);
        bus_if.stall = 1'b0; #1;
        chk("g_take", {31'd0, bus_if.take_irq}, 32'h1);
        tick(); #1;
        chk("g_isv", {29'd0, bus_if.in_service}, 32'h2);

        // Global enable gating
        do_reset();
        bus_if.ie_we = 1'b1; bus_if.ie_wdata = 1'b0;
        tick(); bus_if.ie_we = 1'b0; #1;
        chk("h_ie", {31'd0, bus_if.ie}, 32'h0);
        bus_if.irq_in = 3'b001;
        tick(); bus_if.irq_in = 3'b000; #1;
        chk("h_no_take", {31'd0, bus_if.take_irq}, 32'h0);
        bus_if.ie_we = 1'b1; bus_if.ie_wdata = 1'b1; #1;
        chk("h_write_cycle", {31'd0, bus_if.take_irq}, 32'h0);
        tick(); bus_if.ie_we = 1'b0; #1;
        chk("h_take", {31'd0, bus_if.take_irq}, 32'h1);
        tick();

        // New edge on the winner in its take cycle keeps pending set
        do_reset();
        bus_if.mask_we = 1'b1; bus_if.mask_wdata = 3'b001; bus_if.irq_in = 3'b001;
        tick(); bus_if.mask_we = 1'b0; bus_if.irq_in = 3'b000;
        tick();
        bus_if.mask_we = 1'b1; bus_if.mask_wdata = 3'b000;
        tick(); bus_if.mask_we = 1'b0; bus_if.irq_in = 3'b001; bus_if.pc_next = 32'h90; #1;
        chk("j_take", {31'd0, bus_if.take_irq}, 32'h1);
        tick(); bus_if.irq_in = 3'b000; #1;
        chk("j_pending", {29'd0, bus_if.pending}, 32'h1);
        chk("j_isv", {29'd0, bus_if.in_service}, 32'h1);

        // Reset mid-handler at depth 2
        do_reset();
        bus_if.irq_in = 3'b001; bus_if.pc_next = 32'hA0;
        tick(); bus_if.irq_in = 3'b000;
        tick();
        bus_if.irq_in = 3'b100; bus_if.pc_next = 32'hB0;
        tick(); bus_if.irq_in = 3'b000;
        tick(); #1;
        chk("i_depth2", {30'd0, bus_if.depth}, 32'h2);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("i_depth", {30'd0, bus_if.depth}, 32'h0);
        chk("i_isv", {29'd0, bus_if.in_service}, 32'h0);
        chk("i_ie", {31'd0, bus_if.ie}, 32'h1);
        chk("i_eret_target", bus_if.eret_target, 32'h0);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
